seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clk cycles per digit slot (min 2).
REQ-002 Parameter BLINK_DIV, default 25000000: clk cycles per blink half-period (min 2).
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 state  input  2  display mode: 0 clock, 1 set, 2 seconds, 3 off.
REQ-006 ones, tens, hundreds, thousands  input  4 each  BCD digits from upstream digit splitter.
REQ-007 an  output  4  digit anodes, active-low; an[0] = ones position, an[3] = thousands.
REQ-008 seg  output  7  segments, active-low; seg[6]=a ... seg[0]=g.
REQ-009 dp  output  1  decimal point / colon, active-low.

Function
REQ-010 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; the terminal count SHALL pulse slot_tick for one cycle.
REQ-011 A 2-bit digit select SHALL advance 0->1->2->3->0 on each slot_tick.
REQ-012 On a slot_tick that wraps select from 3 to 0, the four digit inputs and state SHALL be captured into a shadow register; a frame SHALL always display one coherent snapshot.
REQ-013 an, seg and dp SHALL be registered and SHALL reflect the new select one cycle after slot_tick.
REQ-014 Exactly one an bit SHALL be low at any time outside reset and outside state 3.
REQ-015 Digit decode: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; values 10-15 SHALL display dash 1111110.
REQ-016 Blink counter SHALL count 0..BLINK_DIV-1 and toggle blink_phase on wrap; it SHALL run freely in all states.
REQ-017 Shadow state 1: when blink_phase=1, positions 2 and 3 SHALL show seg=1111111 (anode still driven); positions 0 and 1 SHALL display normally.
REQ-018 dp SHALL be low only while position 2 is selected and: state 0 with blink_phase=0, or state 2 (steady); otherwise high.
REQ-019 Shadow state 3: an=1111, seg=1111111, dp=1; scanning counters SHALL keep running.
REQ-020 A change of the state input mid-frame SHALL take effect only at the next frame boundary (REQ-012).

Reset
REQ-021 During reset: prescaler, blink counter, select, blink_phase, shadow digits = 0; shadow state = 3; an=1111; seg=1111111; dp=1.
REQ-022 After reset release, first shadow capture SHALL occur at the first 3->0 select wrap; until then outputs SHALL remain blank per state 3.
REQ-023 Reset asserted mid-frame SHALL take effect immediately, independent of clk.

Configuration
REQ-024 Macro LEAD_ZERO_BLANK_EN: when defined, position 3 SHALL show seg=1111111 whenever its shadow value is 0 (states 0-2); when undefined, 0 SHALL be displayed as 0000001.

Structure
REQ-025 Package seg7_pkg SHALL hold the mode encodings (ST_CLOCK, ST_SET, ST_SECONDS, ST_OFF), the ten digit segment constants, SEG_BLANK and SEG_DASH.
REQ-026 Sub-module seg7_decode (combinational 4-bit to 7-segment, REQ-015) SHALL be instantiated once on the selected shadow digit.

Verification (REFRESH_DIV=4, BLINK_DIV=64)
REQ-027 Reset released, state=0, digits 1,2,3,4 (ones..thousands) -> after first frame, an cycles 1110,1101,1011,0111 every 4 clk with seg 1001111,0010010,0000110,1001100.
REQ-028 state=0, blink_phase toggling -> dp low during an=1011 only for alternate 64-cycle halves; state=2 -> dp low at every an=1011.
REQ-029 state=1, digits 5,9,2,1 -> during blink_phase=1, slots an=1011/0111 show seg=1111111; slots an=1110/1101 show 0100100/0000100.
REQ-030 Change ones from 3 to 7 while select=1 -> ones slot still shows 0000110 until next 3->0 wrap, then 0001111.
REQ-031 ones=12 -> ones slot seg=1111110; state=3 -> an=1111, seg=1111111, dp=1 from next frame.
REQ-032 LEAD_ZERO_BLANK_EN defined, thousands=0 -> an=0111 slot seg=1111111; undefined -> 0000001.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - display mode encodings, segment patterns and frame snapshot type for the 4-digit scan driver
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_CLOCK   = 2'd0,
        ST_SET     = 2'd1,
        ST_SECONDS = 2'd2,
        ST_OFF     = 2'd3
    } mode_e;

    // Active-low segment patterns, bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    localparam logic [3:0] AN_NONE   = 4'b1111;

    typedef struct packed {
        mode_e      mode;
        logic [3:0] thousands;
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } snap_t;

    function automatic logic [3:0] pick_digit(input snap_t s, input logic [1:0] sel);
        logic [3:0] d;
        case (sel)
            2'd0:    d = s.ones;
            2'd1:    d = s.tens;
            2'd2:    d = s.hundreds;
            default: d = s.thousands;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD to active-low 7-segment decoder; non-BCD codes show a dash
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed 7-segment scan driver with per-frame snapshot and blink
// Optional build macro: LEAD_ZERO_BLANK_EN blanks a zero in the thousands position.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] state,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic [1:0]    sel_q, sel_d;
    snap_t         snap_q, snap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          slot_tick;
    logic [6:0]    dec_seg;

    assign slot_tick = (presc_q == PRESC_LAST);

    always_comb begin
        presc_d     = slot_tick ? '0 : presc_q + 1'b1;
        sel_d       = slot_tick ? sel_q + 2'd1 : sel_q;
        blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
        blink_d     = (blink_cnt_q == BLINK_LAST) ? ~blink_q : blink_q;
        snap_d      = snap_q;
        // The snapshot only changes at the frame boundary so a frame never mixes old and new values
        if (slot_tick && (sel_q == 2'd3)) begin
            snap_d.mode      = mode_e'(state);
            snap_d.thousands = thousands;
            snap_d.hundreds  = hundreds;
            snap_d.tens      = tens;
            snap_d.ones      = ones;
        end
    end

    // Outputs are built from next-state values so they register on the same edge as the select
    seg7_decode u_decode (
        .digit (pick_digit(snap_d, sel_d)),
        .seg   (dec_seg)
    );

    always_comb begin
        an_d  = AN_NONE;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (snap_d.mode != ST_OFF) begin
            an_d  = ~(4'b0001 << sel_d);
            seg_d = dec_seg;
            if ((snap_d.mode == ST_SET) && blink_d && sel_d[1]) begin
                seg_d = SEG_BLANK;
            end
`ifdef LEAD_ZERO_BLANK_EN
            if ((sel_d == 2'd3) && (snap_d.thousands == 4'd0)) begin
                seg_d = SEG_BLANK;
            end
`else
`endif
            if ((sel_d == 2'd2) &&
                (((snap_d.mode == ST_CLOCK) && !blink_d) || (snap_d.mode == ST_SECONDS))) begin
                dp_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q          <= '0;
            blink_cnt_q      <= '0;
            blink_q          <= 1'b0;
            sel_q            <= 2'd0;
            snap_q.mode      <= ST_OFF;
            snap_q.thousands <= 4'd0;
            snap_q.hundreds  <= 4'd0;
            snap_q.tens      <= 4'd0;
            snap_q.ones      <= 4'd0;
            an_q             <= AN_NONE;
            seg_q            <= SEG_BLANK;
            dp_q             <= 1'b1;
        end else begin
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            sel_q       <= sel_d;
            snap_q      <= snap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver against a frame-level reference model
module tb_seg7_scan_driver;

    localparam int RD = 4;
    localparam int BD = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state = 2'd0;
    logic [3:0] ones = 4'd0, tens = 4'd0, hundreds = 4'd0, thousands = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk       (clk),
        .reset     (reset),
        .state     (state),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: n = rising edges since reset release, snapshot of last frame boundary
    int n;
    int snap_st;
    int snap_dig[4];

    function automatic logic [6:0] digit_pattern(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    function automatic exp_t model_out(input int cyc);
        exp_t e;
        int   pos;
        int   blink;
        e.n   = cyc;
        e.an  = 4'b1111;
        e.seg = 7'b1111111;
        e.dp  = 1'b1;
        pos   = (cyc / RD) % 4;
        blink = (cyc / BD) % 2;
        if (snap_st != 3) begin
            e.an  = 4'b1111;
            e.an[pos] = 1'b0;
            e.seg = digit_pattern(snap_dig[pos]);
            if (snap_st == 1 && blink == 1 && pos >= 2) e.seg = 7'b1111111;
`ifdef LEAD_ZERO_BLANK_EN
            if (pos == 3 && snap_dig[3] == 0) e.seg = 7'b1111111;
`else
`endif
            if (pos == 2 && ((snap_st == 0 && blink == 0) || snap_st == 2)) e.dp = 1'b0;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
                errors++;
                $display("FAIL scan n=%0d an=%b want %b seg=%b want %b dp=%b want %b",
                         e.n, an, e.an, seg, e.seg, dp, e.dp);
            end
        end
    end

    task automatic check_blank(input string name);
        checks++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
            errors++;
            $display("FAIL %s an=%b seg=%b dp=%b want 1111 1111111 1", name, an, seg, dp);
        end
    endtask

    task automatic set_inputs(input int st, input int d0, input int d1, input int d2, input int d3);
        state     = 2'(st);
        ones      = 4'(d0);
        tens      = 4'(d1);
        hundreds  = 4'(d2);
        thousands = 4'(d3);
    endtask

    task automatic run_cycles(input int k, input bit randomize_inputs);
        repeat (k) begin
            @(posedge clk);
            n++;
            if (n % (4 * RD) == 0) begin
                snap_st     = int'(state);
                snap_dig[0] = int'(ones);
                snap_dig[1] = int'(tens);
                snap_dig[2] = int'(hundreds);
                snap_dig[3] = int'(thousands);
            end
            sbq.push_back(model_out(n));
            #1;
            if (randomize_inputs && $urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0: state     = 2'($urandom_range(0, 3));
                    1: ones      = 4'($urandom_range(0, 15));
                    2: tens      = 4'($urandom_range(0, 15));
                    3: hundreds  = 4'($urandom_range(0, 15));
                    default: thousands = 4'($urandom_range(0, 15));
                endcase
            end
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        snap_st = 3;
        for (int i = 0; i < 4; i++) snap_dig[i] = 0;
    endtask

    initial begin
        set_inputs(0, 1, 2, 3, 4);
        #12;
        check_blank("reset_initial");
        release_reset();

        // clock mode, digits 1..4, covers both blink phases
        run_cycles(200, 1'b0);
        // seconds mode: steady colon
        set_inputs(2, 1, 2, 3, 4);
        run_cycles(80, 1'b0);
        // set mode: upper positions blink
        set_inputs(1, 5, 9, 2, 1);
        run_cycles(150, 1'b0);
        // ones 3 -> 7 changed mid-frame
        set_inputs(0, 3, 0, 0, 0);
        run_cycles(16 - (n % 16) + 5, 1'b0);
        ones = 4'd7;
        run_cycles(40, 1'b0);
        // non-BCD value and then off mode
        set_inputs(0, 12, 15, 10, 0);
        run_cycles(40, 1'b0);
        state = 2'd3;
        run_cycles(40, 1'b0);

        // asynchronous reset mid-frame, checked without a clock edge
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_blank("async_reset");
        run_idle();
        check_blank("reset_held");
        set_inputs(0, 8, 6, 0, 0);
        release_reset();
        run_cycles(14, 1'b0);

        // randomized traffic
        run_cycles(1500, 1'b1);

        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic run_idle();
        repeat (3) @(posedge clk);
        #1;
    endtask

endmodule
